// File: rtl/gf32_mul_shared_arb.sv
// gf32_mul_shared_arb: round-robin arbiter sharing one pipelined GF32 multiplier among N requesters,
// with an in-order tag FIFO routing each result back to its issuer.
module gf32_mul_shared_arb #(
    parameter int N     = 3,
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req,
    input  logic [32*N-1:0]   i_x,
    input  logic [32*N-1:0]   i_y,
    output logic [N-1:0]      o_gnt,
    output logic [N-1:0]      o_done,
    output logic [31:0]       o_res,
    output logic              o_mul_start,
    output logic [31:0]       o_mul_x,
    output logic [31:0]       o_mul_y,
    input  logic [31:0]       i_mul_o,
    input  logic              i_mul_done,
    output logic              o_busy,
    output logic              o_err
);
    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] g;
    logic [SW-1:0] s;
    logic          hit;
    logic [IW-1:0] tags [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          err;
    logic          full;
    logic          issue;
    logic          pop;
    logic          spur;

    always_comb begin
        s   = '0;
        g   = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, rr_ptr} + SW'(k);
            s = (s >= SW'(N)) ? s - SW'(N) : s;
            if (!hit && i_req[s[IW-1:0]]) begin
                hit = 1'b1;
                g   = s[IW-1:0];
            end
        end
    end

    // a full FIFO still accepts when a pop frees a slot in the same cycle
    assign full        = (count == CW'(DEPTH));
    assign issue       = hit && !i_rst && (!full || i_mul_done);
    assign pop         = i_mul_done && !i_rst && (count != '0);
    assign spur        = i_mul_done && !i_rst && (count == '0);
    assign o_gnt       = issue ? N'(1) << g : '0;
    assign o_mul_start = issue;
    assign o_mul_x     = issue ? i_x[32*g +: 32] : '0;
    assign o_mul_y     = issue ? i_y[32*g +: 32] : '0;
    assign o_done      = pop ? N'(1) << tags[rd_ptr] : '0;
    assign o_res       = pop ? i_mul_o : '0;
    assign o_busy      = (count != '0);
    assign o_err       = err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (issue) begin
                tags[wr_ptr] <= g;
                wr_ptr       <= wr_ptr + 1'b1;
                rr_ptr       <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(issue) - CW'(pop);
            err   <= err | spur;
        end
    end
endmodule

// File: tb/tb_gf32_mul_shared_arb.sv
// tb_gf32_mul_shared_arb: directed scenario tests for the shared GF32 multiplier arbiter (N=3, DEPTH=4);
// the multiplier is played by the bench, which drives i_mul_done/i_mul_o on chosen cycles.
module tb_gf32_mul_shared_arb;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_req;
    logic [95:0] i_x;
    logic [95:0] i_y;
    logic [2:0]  o_gnt;
    logic [2:0]  o_done;
    logic [31:0] o_res;
    logic        o_mul_start;
    logic [31:0] o_mul_x;
    logic [31:0] o_mul_y;
    logic [31:0] i_mul_o;
    logic        i_mul_done;
    logic        o_busy;
    logic        o_err;
    int          n_chk = 0;
    int          n_pass = 0;

    gf32_mul_shared_arb #(.N(3), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_x(i_x), .i_y(i_y),
        .o_gnt(o_gnt), .o_done(o_done), .o_res(o_res), .o_mul_start(o_mul_start),
        .o_mul_x(o_mul_x), .o_mul_y(o_mul_y), .i_mul_o(i_mul_o), .i_mul_done(i_mul_done),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_req = '0; i_mul_done = 1'b0; i_mul_o = '0;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req = 3'b111; i_mul_done = 1'b1; i_mul_o = 32'hDEAD_BEEF;
        i_x = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        i_y = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444};
        #1;
        n_chk++;
        if ({o_gnt, o_done, o_mul_start} !== 7'b0) $display("FAIL rst_strobes got gnt=%b done=%b start=%b want 0", o_gnt, o_done, o_mul_start);
        else n_pass++;
        n_chk++;
        if ({o_mul_x, o_mul_y, o_res} !== 96'b0) $display("FAIL rst_data got x=%h y=%h res=%h want 0", o_mul_x, o_mul_y, o_res);
        else n_pass++;
        tick();
        i_rst = 1'b0; i_req = '0; i_mul_done = 1'b0;
        #1;
        n_chk++;
        if ({o_busy, o_err} !== 2'b00) $display("FAIL rst_flags got busy=%b err=%b want 0 0", o_busy, o_err);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        i_req = 3'b010;
        i_x = {32'hAAAA_AAAA, 32'h0203_0405, 32'h5555_5555};
        i_y = {32'hCCCC_CCCC, 32'h0101_0101, 32'h3333_3333};
        #1;
        n_chk++;
        if (o_gnt !== 3'b010 || o_mul_start !== 1'b1) $display("FAIL single_gnt got %b start=%b want 010 1", o_gnt, o_mul_start);
        else n_pass++;
        n_chk++;
        if (o_mul_x !== 32'h0203_0405 || o_mul_y !== 32'h0101_0101) $display("FAIL single_ops got %h %h want 02030405 01010101", o_mul_x, o_mul_y);
        else n_pass++;
        tick();
        i_req = '0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_chk++;
            if (o_busy !== 1'b1 || o_done !== 3'b000) $display("FAIL single_busy_c%0d got busy=%b done=%b want 1 000", c, o_busy, o_done);
            else n_pass++;
            tick();
        end
        i_mul_done = 1'b1; i_mul_o = 32'h0203_0405 ^ 32'h0101_0101;
        #1;
        n_chk++;
        if (o_done !== 3'b010 || o_res !== 32'h0302_0504 || o_busy !== 1'b1) $display("FAIL single_done got done=%b res=%h busy=%b want 010 03020504 1", o_done, o_res, o_busy);
        else n_pass++;
        tick();
        i_mul_done = 1'b0;
        #1;
        n_chk++;
        if (o_busy !== 1'b0 || o_done !== 3'b000 || o_res !== 32'h0) $display("FAIL single_idle got busy=%b done=%b res=%h want 0 000 0", o_busy, o_done, o_res);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        i_x = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        i_rst = 1'b1; i_req = 3'b111; i_mul_done = 1'b0;
        tick();
        i_rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            i_req = (c < 6) ? 3'b111 : 3'b000;
            i_mul_done = (c >= 3);
            i_mul_o = 32'hC0DE_0000 + 32'(c);
            #1;
            if (c < 6) begin
                n_chk++;
                if (o_gnt !== seq[c]) $display("FAIL cont_gnt_c%0d got %b want %b", c, o_gnt, seq[c]);
                else n_pass++;
            end
            if (c >= 3) begin
                n_chk++;
                if (o_done !== seq[c-3] || o_res !== 32'hC0DE_0000 + 32'(c)) $display("FAIL cont_done_c%0d got %b/%h want %b/%h", c, o_done, o_res, seq[c-3], 32'hC0DE_0000 + 32'(c));
                else n_pass++;
            end
            tick();
        end
        i_mul_done = 1'b0;
        #1;
        n_chk++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) $display("FAIL cont_end got busy=%b err=%b want 0 0", o_busy, o_err);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [2:0] want [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000};
        do_reset();
        i_req = 3'b111;
        for (int c = 0; c < 8; c++) begin
            i_mul_done = (c == 6);
            i_mul_o = 32'h0F0F_0F0F;
            #1;
            n_chk++;
            if (o_gnt !== want[c]) $display("FAIL full_gnt_c%0d got %b want %b", c, o_gnt, want[c]);
            else n_pass++;
            if (c == 6) begin
                n_chk++;
                if (o_done !== 3'b001 || o_res !== 32'h0F0F_0F0F) $display("FAIL full_pop got %b/%h want 001/0f0f0f0f", o_done, o_res);
                else n_pass++;
            end
            tick();
        end
        i_req = '0;
        i_mul_done = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        i_mul_done = 1'b1; i_mul_o = 32'h1234_5678;
        #1;
        n_chk++;
        if (o_done !== 3'b000 || o_res !== 32'h0 || o_err !== 1'b0) $display("FAIL spur_strobe got done=%b res=%h err=%b want 000 0 0", o_done, o_res, o_err);
        else n_pass++;
        tick();
        i_mul_done = 1'b0;
        tick(); tick();
        n_chk++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) $display("FAIL spur_sticky got err=%b busy=%b want 1 0", o_err, o_busy);
        else n_pass++;
        do_reset();
        #1;
        n_chk++;
        if (o_err !== 1'b0) $display("FAIL spur_clear got %b want 0", o_err);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        i_req = 3'b011;
        #1;
        n_chk++;
        if (o_gnt !== 3'b001) $display("FAIL mid_g0 got %b want 001", o_gnt);
        else n_pass++;
        tick();
        i_req = 3'b010;
        #1;
        n_chk++;
        if (o_gnt !== 3'b010) $display("FAIL mid_g1 got %b want 010", o_gnt);
        else n_pass++;
        tick();
        i_req = '0; i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_req = 3'b101;
        #1;
        n_chk++;
        if (o_busy !== 1'b0 || o_gnt !== 3'b001) $display("FAIL mid_after got busy=%b gnt=%b want 0 001", o_busy, o_gnt);
        else n_pass++;
        tick();
        i_req = 3'b100; i_mul_done = 1'b1; i_mul_o = 32'hAAAA_5555;
        #1;
        n_chk++;
        if (o_gnt !== 3'b100 || o_done !== 3'b001) $display("FAIL mid_r2 got gnt=%b done=%b want 100 001", o_gnt, o_done);
        else n_pass++;
        tick();
        i_req = '0;
        #1;
        n_chk++;
        if (o_done !== 3'b100 || o_busy !== 1'b1) $display("FAIL mid_pop2 got done=%b busy=%b want 100 1", o_done, o_busy);
        else n_pass++;
        tick();
        #1;
        n_chk++;
        if (o_done !== 3'b000 || o_err !== 1'b0) $display("FAIL mid_stale_pre got done=%b err=%b want 000 0", o_done, o_err);
        else n_pass++;
        tick();
        i_mul_done = 1'b0;
        #1;
        n_chk++;
        if (o_err !== 1'b1) $display("FAIL mid_stale_err got %b want 1", o_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_spurious();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
